// File: rtl/alu_pkg.sv
// Shared opcode encodings and response record for the ALU stream unit.
// Top-level WIDTH must equal ALU_W because the response struct is sized by it.
package alu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_SUB = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic             carry;
        logic             zero;
    } rsp_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: ADD/AND/SUB/OR with carry (borrow for SUB) and zero flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit of the difference is the borrow, i.e. a < b.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (op_t'(op))
            OP_ADD: {carry, result} = sum;
            OP_SUB: {carry, result} = diff;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            default: ;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_stream_unit.sv
// Valid/ready front end for alu_core: results are pushed into an in-order
// response FIFO whose head registers drive the rsp_* outputs directly.
module alu_stream_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [7:0]       op_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    rsp_t             mem [DEPTH];
    rsp_t             core_rsp;
    rsp_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (req_a),
        .b      (req_b),
        .op     (req_op),
        .result (core_rsp.result),
        .carry  (core_rsp.carry),
        .zero   (core_rsp.zero)
    );

    // Ready depends only on occupancy, never on rsp_ready.
    assign req_ready = (count != FULL_CNT);
    assign rsp_valid = (count != '0);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // NOTE: the storage is reset because the head entry drives rsp_* and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            op_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push) begin
                mem[wr_ptr] <= core_rsp;
                wr_ptr      <= wr_ptr + 1'b1;
                op_count    <= op_count + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign rsp_result = head.result;
    assign rsp_carry  = head.carry;
    assign rsp_zero   = head.zero;

endmodule

// File: tb/tb_alu_stream_unit.sv
// Self-checking bench for alu_stream_unit: directed vector table plus
// back-pressure, streaming and mid-stream reset sequences.
module tb_alu_stream_unit;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [1:0] req_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;
    logic [7:0] op_count;

    int checks;
    int failures;

    alu_stream_unit #(.WIDTH(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] res;
        logic       c;
        logic       z;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference ALU written from the arithmetic definition: {result, carry, zero}.
    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int         s;
        logic [3:0] r;
        logic       c;
        r = 4'd0;
        c = 1'b0;
        case (op)
            2'd0: begin s = int'(a) + int'(b); r = 4'(s % 16); c = (s > 15); end
            2'd1: r = a & b;
            2'd2: begin s = int'(a) - int'(b) + 16; r = 4'(s % 16); c = (a < b); end
            default: r = a | b;
        endcase
        return {r, c, (r == 4'd0)};
    endfunction

    function automatic logic [5:0] head_bits();
        return {rsp_result, rsp_carry, rsp_zero};
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;

        vecs[0] = '{4'b0010, 4'b1000, 2'b00, 4'b1010, 1'b0, 1'b0};
        vecs[1] = '{4'b1111, 4'b0101, 2'b00, 4'b0100, 1'b1, 1'b0};
        vecs[2] = '{4'b0001, 4'b0010, 2'b10, 4'b1111, 1'b1, 1'b0};
        vecs[3] = '{4'b1110, 4'b0001, 2'b01, 4'b0000, 1'b0, 1'b1};
        vecs[4] = '{4'b1010, 4'b0101, 2'b11, 4'b1111, 1'b0, 1'b0};
        vecs[5] = '{4'b0101, 4'b0011, 2'b10, 4'b0010, 1'b0, 1'b0};
        vecs[6] = '{4'b0011, 4'b0011, 2'b10, 4'b0000, 1'b0, 1'b1};
        vecs[7] = '{4'b1000, 4'b1000, 2'b00, 4'b0000, 1'b1, 1'b1};
        vecs[8] = '{4'b1100, 4'b1010, 2'b01, 4'b1000, 1'b0, 1'b0};
        vecs[9] = '{4'b0000, 4'b0000, 2'b11, 4'b0000, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_head",      32'(head_bits()), 32'd0);
        check("reset_op_count",  32'(op_count), 32'd0);
        rst_n = 1'b1;

        // Directed vectors, one at a time with rsp_ready=1
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_empty", i), 32'(rsp_valid), 32'd0);
            drive(vecs[i].a, vecs[i].b, vecs[i].op);
            @(negedge clk);
            req_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("vec%0d_data", i), 32'(head_bits()),
                  32'({vecs[i].res, vecs[i].c, vecs[i].z}));
            check($sformatf("vec%0d_op_count", i), 32'(op_count), 32'(i + 1));
        end

        // Back-pressure: two accepted, third stalls until the first pop
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(4'd1, 4'd2, 2'b00);
        @(negedge clk);
        drive(4'd7, 4'd1, 2'b10);
        @(negedge clk);
        drive(4'b1000, 4'b0001, 2'b11);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_stall_ready%0d", i), 32'(req_ready), 32'd0);
            check($sformatf("bp_hold_data%0d", i), 32'(head_bits()), 32'({4'd3, 1'b0, 1'b0}));
            check($sformatf("bp_hold_valid%0d", i), 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        check("bp_op_count", 32'(op_count), 32'd12);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_second_data", 32'(head_bits()), 32'({4'd6, 1'b0, 1'b0}));
        check("bp_ready_after_pop", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_third_data", 32'(head_bits()), 32'({4'b1001, 1'b0, 1'b0}));
        check("bp_third_valid", 32'(rsp_valid), 32'd1);
        check("bp_op_count_final", 32'(op_count), 32'd13);
        @(negedge clk);
        check("bp_drained", 32'(rsp_valid), 32'd0);

        // Streaming 300 back-to-back ops from a fresh reset
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k <= 300; k++) begin
            if (k > 0) begin
                logic [3:0] pa;
                logic [3:0] pb;
                pa = 4'(k - 1);
                pb = 4'((k - 1) * 7 + 3);
                check($sformatf("stream%0d_valid", k - 1), 32'(rsp_valid), 32'd1);
                check($sformatf("stream%0d_data", k - 1), 32'(head_bits()),
                      32'(model(pa, pb, 2'(k - 1))));
            end
            if (k < 300) drive(4'(k), 4'(k * 7 + 3), 2'(k));
            else req_valid = 1'b0;
            @(negedge clk);
        end
        check("stream_op_count", 32'(op_count), 32'd44);
        check("stream_drained", 32'(rsp_valid), 32'd0);

        // Asynchronous reset with two entries queued
        rsp_ready = 1'b0;
        drive(4'd9, 4'd4, 2'b00);
        @(negedge clk);
        drive(4'd2, 4'd2, 2'b01);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_full", 32'(req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    32'(rsp_valid), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_ready",    32'(req_ready), 32'd1);
        check("mid_rst_head",     32'(head_bits()), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        drive(4'b1000, 4'b0011, 2'b10);
        @(negedge clk);
        req_valid = 1'b0;
        check("post_rst_valid",    32'(rsp_valid), 32'd1);
        check("post_rst_data",     32'(head_bits()), 32'({4'b0101, 1'b0, 1'b0}));
        check("post_rst_op_count", 32'(op_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_stream_unit.md
# alu_stream_unit

Handshaked, buffered front end for the 4-bit ALU datapath. It accepts operation requests (operands plus opcode) on a valid/ready request port and computes the result and flags in a combinational ALU core. Results are queued in a small response FIFO and returned in order on a valid/ready response port. It sits between an operation issuer (sequencer or bench) and the result consumer, turning the bare combinational ALU into a flow-controlled pipeline stage.

## Interface
- WIDTH, 4, operand/result width in bits
- DEPTH, 2, response FIFO entries (power of two, ≥2)
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_a  input  WIDTH  operand A
- req_b  input  WIDTH  operand B
- req_op  input  2  opcode: 00 ADD, 01 AND, 10 SUB, 11 OR
- rsp_valid  output  1  response FIFO head valid
- rsp_ready  input  1  consumer takes head this cycle
- rsp_result  output  WIDTH  result at FIFO head
- rsp_carry  output  1  carry/borrow flag at head
- rsp_zero  output  1  result==0 flag at head
- op_count  output  8  number of accepted requests, wraps 255→0

## Operation
- Accept: req_valid && req_ready at a rising edge. Compute the result from req_a/req_b/req_op in the same cycle and push {result, carry, zero} into the FIFO on that edge.
- Arithmetic:
  - ADD: {carry, result} = A + B, computed at WIDTH+1 bits.
  - SUB: result = A − B mod 2^WIDTH; carry = 1 iff A < B (borrow).
  - AND/OR: bitwise; carry = 0.
  - zero = (result == 0) for all ops.
- Pop: rsp_valid && rsp_ready at a rising edge removes the head.
- req_ready = !full. It has no combinational dependence on rsp_ready; a full FIFO stalls requests even when a pop happens in the same cycle.
- Simultaneous push and pop (not full, not empty): both occur and the occupancy count is unchanged.
- Simultaneous push and pop with occupancy 0: not possible, because rsp_valid=0. The push lands and rsp_valid rises next cycle.
- Pop request while empty: ignored. Push while full: cannot occur, because req_ready=0.
- Pointers wrap modulo DEPTH. The occupancy counter has log2(DEPTH)+1 bits.
- op_count increments on every accept and wraps silently.
- Responses stay strictly in request order. An undefined req_op value never occurs, because the 2-bit encoding is full.

## Timing
- Reset (rst_n low, asynchronous): FIFO empty, pointers 0.
  - Outputs: rsp_valid=0, req_ready=1, rsp_result=0, rsp_carry=0, rsp_zero=0, op_count=0.
- Reset asserted mid-operation immediately discards all queued responses. Outputs take reset values without waiting for a clock edge.
- Latency: accept at edge N gives rsp_valid=1 with that result after edge N (visible in cycle N+1), provided the FIFO was empty.
- Throughput: one op per cycle while the consumer holds rsp_ready=1.
- rsp_* outputs are driven from the FIFO head registers.
- Response data must stay stable while rsp_valid=1 && rsp_ready=0.
- The request side may change req_a/req_b/req_op freely while req_ready=0. Only values present at the accepting edge are used.

## Structure
- Shared package alu_pkg holds:
  - op encodings OP_ADD=2'b00, OP_AND=2'b01, OP_SUB=2'b10, OP_OR=2'b11
  - a packed response struct {result, carry, zero}
- Sub-module alu_core: purely combinational. It takes A, B and op and produces result, carry and zero. Instantiated once.
- FIFO storage, pointers, occupancy and op_count stay in the top module.

## Test plan
- Reset, then ADD 4'b0010 + 4'b1000 with rsp_ready=1 → one cycle later rsp_result=4'b1010, carry=0, zero=0, op_count=1.
- ADD 4'b1111 + 4'b0101 → result=4'b0100, carry=1 (overflow). SUB 4'b0001 − 4'b0010 → result=4'b1111, carry=1.
- AND 4'b1110 & 4'b0001 → result=0, zero=1, carry=0. OR 4'b1010 | 4'b0101 → 4'b1111.
- Back-pressure with rsp_ready=0:
  - Issue 3 requests; 2 are accepted, then req_ready=0.
  - Hold the response stable for 5 cycles.
  - Release rsp_ready: responses return in order, and req_ready rises the cycle after the first pop.
- Streaming 300 back-to-back ops with rsp_ready=1 → one response per cycle, none lost or reordered, op_count=44 (300 mod 256).
- Assert rst_n low mid-stream with 2 entries queued → rsp_valid=0 and op_count=0 immediately. After release, the first new request returns correctly with latency 1.
